l1_cache_ctrl: RTL and testbench
================================

Name: l1_cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate L1 cache controller.
- Sits between the core load/store unit and the main-memory interface, and owns the line storage behind it.
- Serialises one core request at a time.
- Refills a line word-by-word from main memory on a read miss.
- Exposes hit/miss counters for performance analysis.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, word width.
- LINES, 16, number of lines (power of 2).
- WORDS_PER_LINE, 4, words per line (power of 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1=store, 0=load.
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  one-cycle pulse: load data or store acknowledge.
- resp_rdata  out  DATA_W  load data, valid with resp_valid.
- flush  in  1  invalidate all lines.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  word-aligned memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_resp_valid  in  1  memory read data valid.
- mem_rdata  in  DATA_W  memory read data.
- hit_cnt  out  16  lookup hit count, wraps.
- miss_cnt  out  16  lookup miss count, wraps.

Behaviour:
- Clocking and reset: single clock domain, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State IDLE; all valid bits cleared.
  - req_ready=1; resp_valid=0, resp_rdata=0.
  - mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - hit_cnt=0, miss_cnt=0.
- Address split (defaults):
  - word offset = addr[3:2]
  - index = addr[7:4]
  - tag = addr[31:8]
  - Widths derive from the parameters via $clog2.
- States: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, MEM_WRITE, RESP.
- IDLE:
  - req_ready=1 only in IDLE and only when flush=0.
  - flush=1 clears all valid bits on that edge and stays in IDLE. Flush has priority over req_valid.
  - On req_valid&&req_ready the request (we, addr, wdata) is latched; go to LOOKUP.
  - flush outside IDLE is ignored; the source holds it until req_ready returns.
- LOOKUP (hit = valid[index] && tag match):
  - Every lookup increments exactly one of hit_cnt / miss_cnt.
  - Load hit: go to RESP with the array word.
  - Load miss: go to REFILL_REQ with word counter=0.
  - Store hit: update the array word; go to MEM_WRITE.
  - Store miss: array unchanged; go to MEM_WRITE.
- REFILL_REQ / REFILL_WAIT:
  - REFILL_REQ drives mem_req_valid=1, mem_we=0, mem_addr={tag,index,cnt,2'b00}. It holds until mem_req_ready, then moves to REFILL_WAIT.
  - Refill order is sequential from the line base, cnt 0..WORDS_PER_LINE-1. One outstanding request at a time.
  - REFILL_WAIT: on mem_resp_valid, write mem_rdata into array word cnt.
    - If cnt is the last word: set tag and valid; go to RESP.
    - Otherwise: cnt+1; go to REFILL_REQ.
  - The line's valid bit is cleared when refill starts, so a partially filled line is never valid.
  - mem_resp_valid outside REFILL_WAIT is ignored.
- MEM_WRITE: drives mem_req_valid=1, mem_we=1, latched word-aligned addr and wdata. Holds until mem_req_ready, then goes to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; then IDLE.
  - Loads: resp_rdata = requested word. Stores: resp_rdata = 0.
- Latency (from the accept edge to the edge after which resp_valid is high):
  - Load hit: 2 edges.
  - Store: 2 edges + mem_req_ready wait.
  - Load miss: 2 + per-word handshake/response time.
- Memory-side rule: mem_req_valid, once asserted, stays stable with address and data unchanged until mem_req_ready.
- Reset mid-operation: the transaction is abandoned and no response is produced. The refilling line is left invalid.

Decomposition:
- Shared package l1_cache_pkg holds:
  - FSM state encoding.
  - Derived widths: OFF_W, IDX_W, TAG_W.
  - Field-extract functions for tag, index and word offset.
- Sub-module l1_line_store:
  - Valid/tag/data arrays.
  - Combinational read by index.
  - Synchronous word write, tag/valid set.
  - Single-index valid clear; flush-all clear.
  - Asynchronous valid reset.
- The controller FSM and counters live in l1_cache_ctrl.

Test Plan:
- After reset, load 0x0000_0010; memory returns 0xA0,0xA1,0xA2,0xA3 for reads at 0x10,0x14,0x18,0x1C in that order -> resp_rdata=0xA0, miss_cnt=1, hit_cnt=0.
- Load 0x14 after scenario 1 -> resp_valid 2 edges after accept, rdata=0xA1, no mem_req_valid, hit_cnt=1.
- Store 0x18 data 0xDEADBEEF with mem_req_ready delayed 3 cycles -> mem_addr/mem_wdata stable for the whole wait, one write at 0x18, ack pulse. Then load 0x18 -> hit, 0xDEADBEEF.
- Load 0x110 (same index 1, new tag) -> refill from 0x110..0x11C and line replaced. Then load 0x10 -> miss again, miss_cnt increments.
- Store-miss 0x200 -> exactly one mem write, no refill reads. Then load 0x200 -> miss.
- Two sub-cases:
  - Assert flush in IDLE -> req_ready=0 that cycle; a later load 0x14 misses.
  - Assert rst_n=0 after the second refill word -> mem_req_valid=0 and req_ready=1 immediately; a later load 0x10 misses.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// Shared definitions for the L1 cache controller: FSM encoding, default-geometry
// widths and address field extraction helpers.
package l1_cache_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINES_DEF  = 16;
    localparam int WPL_DEF    = 4;

    localparam int OFF_W = $clog2(WPL_DEF);
    localparam int IDX_W = $clog2(LINES_DEF);
    localparam int TAG_W = ADDR_W_DEF - OFF_W - IDX_W - 2;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL_REQ,
        REFILL_WAIT,
        MEM_WRITE,
        RESP
    } state_t;

    // Helpers take the geometry as arguments so any parameterisation can share them.
    function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb,
                                               input int width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (addr >> lsb) & mask;
    endfunction

    function automatic logic [63:0] word_off(input logic [63:0] addr, input int off_w);
        return addr_field(addr, 2, off_w);
    endfunction

    function automatic logic [63:0] line_idx(input logic [63:0] addr, input int off_w,
                                             input int idx_w);
        return addr_field(addr, 2 + off_w, idx_w);
    endfunction

    function automatic logic [63:0] line_tag(input logic [63:0] addr, input int off_w,
                                             input int idx_w);
        return addr >> (2 + off_w + idx_w);
    endfunction

endpackage

// File: rtl/l1_cache_ctrl_line_store.sv
// Line storage for the direct-mapped cache: per-line valid bit and tag plus a
// flat word array, read combinationally by index and written synchronously.
module l1_line_store
    import l1_cache_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_BITS       = 24
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [$clog2(LINES)-1:0]          idx,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] rd_off,
    output logic                              rd_valid,
    output logic [TAG_BITS-1:0]               rd_tag,
    output logic [DATA_W-1:0]                 rd_word,
    input  logic                              wr_en,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] wr_off,
    input  logic [DATA_W-1:0]                 wr_data,
    input  logic                              set_en,
    input  logic [TAG_BITS-1:0]               set_tag,
    input  logic                              clr_en,
    input  logic                              flush_all
);

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [DATA_W-1:0]   data_q [LINES*WORDS_PER_LINE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (flush_all) begin
            valid_q <= '0;
        end else begin
            if (clr_en) valid_q[idx] <= 1'b0;
            if (set_en) valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)  data_q[{idx, wr_off}] <= wr_data;
        if (set_en) tag_q[idx] <= set_tag;
    end

    assign rd_valid = valid_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_word  = data_q[{idx, rd_off}];

endmodule

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 cache controller that
// serialises core requests and refills lines word-by-word from memory.
module l1_cache_ctrl
    import l1_cache_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
    localparam int IDX_BITS = $clog2(LINES);
    localparam int TAG_BITS = ADDR_W - OFF_BITS - IDX_BITS - 2;

    state_t                     state;
    logic                       req_we_q;
    logic [ADDR_W-1:0]          req_addr_q;
    logic [DATA_W-1:0]          req_wdata_q;
    logic [OFF_BITS-1:0]        cnt;
    logic [OFF_BITS-1:0]        cnt_inc;
    logic [OFF_BITS-1:0]        req_off;
    logic [IDX_BITS-1:0]        req_idx;
    logic [TAG_BITS-1:0]        req_tag;
    logic [ADDR_W-OFF_BITS-3:0] line_base;
    logic                       ls_valid;
    logic [TAG_BITS-1:0]        ls_tag;
    logic [DATA_W-1:0]          ls_word;
    logic                       hit;
    logic                       last_word;
    logic                       accept;

    assign req_ready = (state == IDLE) && !flush;
    assign accept    = req_valid && req_ready;

    assign req_off   = OFF_BITS'(word_off(64'(req_addr_q), OFF_BITS));
    assign req_idx   = IDX_BITS'(line_idx(64'(req_addr_q), OFF_BITS, IDX_BITS));
    assign req_tag   = TAG_BITS'(line_tag(64'(req_addr_q), OFF_BITS, IDX_BITS));
    assign line_base = req_addr_q[ADDR_W-1:OFF_BITS+2];
    assign cnt_inc   = cnt + OFF_BITS'(1);
    assign last_word = (cnt == OFF_BITS'(WORDS_PER_LINE - 1));
    assign hit       = ls_valid && (ls_tag == req_tag);

    l1_line_store #(
        .DATA_W         (DATA_W),
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_BITS       (TAG_BITS)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (req_idx),
        .rd_off    (req_off),
        .rd_valid  (ls_valid),
        .rd_tag    (ls_tag),
        .rd_word   (ls_word),
        .wr_en     ((state == LOOKUP && req_we_q && hit) ||
                    (state == REFILL_WAIT && mem_resp_valid)),
        .wr_off    ((state == REFILL_WAIT) ? cnt : req_off),
        .wr_data   ((state == REFILL_WAIT) ? mem_rdata : req_wdata_q),
        .set_en    (state == REFILL_WAIT && mem_resp_valid && last_word),
        .set_tag   (req_tag),
        .clr_en    (state == LOOKUP && !req_we_q && !hit),
        .flush_all (state == IDLE && flush)
    );

    // Request capture: data-only registers, loaded on the accept edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_we_q    <= req_we;
            req_addr_q  <= req_addr;
            req_wdata_q <= req_wdata;
        end
    end

    // Control FSM with registered core- and memory-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) state <= LOOKUP;
                end
                LOOKUP: begin
                    if (hit) hit_cnt  <= hit_cnt + 16'd1;
                    else     miss_cnt <= miss_cnt + 16'd1;
                    if (req_we_q) begin
                        mem_req_valid <= 1'b1;
                        mem_we        <= 1'b1;
                        mem_addr      <= {req_addr_q[ADDR_W-1:2], 2'b00};
                        mem_wdata     <= req_wdata_q;
                        state         <= MEM_WRITE;
                    end else if (hit) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= ls_word;
                        state      <= RESP;
                    end else begin
                        cnt           <= '0;
                        mem_req_valid <= 1'b1;
                        mem_we        <= 1'b0;
                        mem_addr      <= {line_base, {OFF_BITS{1'b0}}, 2'b00};
                        state         <= REFILL_REQ;
                    end
                end
                REFILL_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= REFILL_WAIT;
                    end
                end
                REFILL_WAIT: begin
                    if (mem_resp_valid) begin
                        if (last_word) begin
                            // Earlier words already sit in the array; the last one is still in flight.
                            resp_valid <= 1'b1;
                            resp_rdata <= (cnt == req_off) ? mem_rdata : ls_word;
                            state      <= RESP;
                        end else begin
                            cnt           <= cnt_inc;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= {line_base, cnt_inc, 2'b00};
                            state         <= REFILL_REQ;
                        end
                    end
                end
                MEM_WRITE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_we        <= 1'b0;
                        resp_valid    <= 1'b1;
                        resp_rdata    <= '0;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Scoreboard bench for l1_cache_ctrl: a tag/valid reference model plus a flat
// memory model predict every response, memory read and memory write.
module tb_l1_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, flush;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_we;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [15:0] hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    l1_cache_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    typedef struct {
        logic [31:0] rdata;
        logic [15:0] hits;
        logic [15:0] misses;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] exp_rd[$];
    logic [31:0] exp_wr_a[$];
    logic [31:0] exp_wr_d[$];

    // Reference model: memory contents plus which block each line currently holds.
    logic [31:0] mem_model [logic [31:0]];
    bit          mvalid [16];
    logic [23:0] mtag   [16];
    logic [15:0] mhits, mmisses;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Memory responder and response monitor.
    bit          prev_valid = 0, prev_we = 0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    int          wait_left = 0;
    int          force_delay = -1;
    bit          rd_pending = 0;
    logic [31:0] rd_addr = '0;
    int          rd_delay = 0;
    int          rd_resp_cnt = 0;

    always @(negedge clk) begin : mon
        bit   hs;
        exp_t e;
        if (!rst_n) begin
            prev_valid     = 0;
            rd_pending     = 0;
            wait_left      = 0;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
        end else begin
            hs = prev_valid && mem_req_ready;
            if (hs) begin
                if (prev_we) begin
                    chk("mem_write_expected", exp_wr_a.size() > 0, 1);
                    if (exp_wr_a.size() > 0) begin
                        chk("mem_write_addr", prev_addr, exp_wr_a.pop_front());
                        chk("mem_write_data", prev_wdata, exp_wr_d.pop_front());
                    end
                    mem_model[prev_addr] = prev_wdata;
                end else begin
                    chk("mem_read_expected", exp_rd.size() > 0, 1);
                    if (exp_rd.size() > 0) chk("mem_read_addr", prev_addr, exp_rd.pop_front());
                    chk("one_outstanding_read", rd_pending, 0);
                    rd_pending = 1;
                    rd_addr    = prev_addr;
                    rd_delay   = int'($urandom % 3);
                end
            end else if (prev_valid) begin
                chk("mem_req_hold_valid", mem_req_valid, 1);
                chk("mem_req_hold_we", mem_we, prev_we);
                chk("mem_req_hold_addr", mem_addr, prev_addr);
                chk("mem_req_hold_wdata", mem_wdata, prev_wdata);
            end

            if (mem_req_valid && (!prev_valid || hs))
                wait_left = (force_delay >= 0) ? force_delay : int'($urandom % 3);
            mem_req_ready = mem_req_valid && (wait_left == 0);
            if (mem_req_valid && wait_left > 0) wait_left--;

            mem_resp_valid = 1'b0;
            mem_rdata      = $urandom;
            if (rd_pending) begin
                if (rd_delay == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = mem_rd(rd_addr);
                    rd_pending     = 0;
                    rd_resp_cnt++;
                end else begin
                    rd_delay--;
                end
            end else if ($urandom % 4 == 0) begin
                mem_resp_valid = 1'b1;
            end

            prev_valid = mem_req_valid;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;

            if (resp_valid) begin
                chk("resp_expected", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("hit_cnt", hit_cnt, e.hits);
                    chk("miss_cnt", miss_cnt, e.misses);
                    if (e.chk_lat) chk("hit_latency", cyc - e.acc_cyc, 2);
                    chk("refill_reads_done", exp_rd.size(), 0);
                    chk("store_write_done", exp_wr_a.size(), 0);
                end
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mvalid[i] = 0;
    endtask

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input bit wait_resp);
        int          guard;
        int          idx;
        logic [31:0] wa;
        logic [23:0] tg;
        bit          hit;
        exp_t        e;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        #1;
        guard = 0;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!req_ready) begin
            chk("accept_timeout", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        e.acc_cyc = cyc;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wa  = addr & ~32'h3;
        idx = int'(wa[7:4]);
        tg  = wa[31:8];
        hit = mvalid[idx] && (mtag[idx] == tg);
        if (hit) mhits++;
        else     mmisses++;
        if (we) begin
            exp_wr_a.push_back(wa);
            exp_wr_d.push_back(wd);
            e.rdata   = '0;
            e.chk_lat = 0;
        end else begin
            e.rdata   = mem_rd(wa);
            e.chk_lat = hit;
            if (!hit) begin
                for (int w = 0; w < 4; w++) exp_rd.push_back({wa[31:4], 4'h0} + 32'(4 * w));
                mvalid[idx] = 1;
                mtag[idx]   = tg;
            end
        end
        e.hits   = mhits;
        e.misses = mmisses;
        sb_q.push_back(e);
        if (wait_resp) begin
            guard = 0;
            while (sb_q.size() > 0 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (sb_q.size() > 0) begin
                chk("resp_timeout", sb_q.size(), 0);
                sb_q.delete();
            end
        end
    endtask

    task automatic do_flush(input bit with_req);
        @(negedge clk);
        flush = 1'b1;
        if (with_req) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = 32'h14;
        end
        #1 chk("flush_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        clear_model();
    endtask

    initial begin : stim
        int          r0;
        int          guard;
        logic [31:0] a;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        flush     = 1'b0;
        mhits     = '0;
        mmisses   = '0;
        clear_model();
        mem_model[32'h10] = 32'hA0;
        mem_model[32'h14] = 32'hA1;
        mem_model[32'h18] = 32'hA2;
        mem_model[32'h1C] = 32'hA3;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        do_req(0, 32'h10, '0, 1);
        do_req(0, 32'h14, '0, 1);
        force_delay = 3;
        do_req(1, 32'h18, 32'hDEAD_BEEF, 1);
        force_delay = -1;
        do_req(0, 32'h18, '0, 1);
        do_req(0, 32'h110, '0, 1);
        do_req(0, 32'h10, '0, 1);
        do_req(1, 32'h200, 32'h1234_5678, 1);
        do_req(0, 32'h200, '0, 1);

        do_flush(1);
        do_req(0, 32'h14, '0, 1);

        // Reset in the middle of a refill, after two words have been delivered.
        do_flush(0);
        r0 = rd_resp_cnt;
        do_req(0, 32'h10, '0, 0);
        guard = 0;
        while (rd_resp_cnt < r0 + 2 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("refill_progress", rd_resp_cnt >= r0 + 2, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mem_req_valid", mem_req_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_resp_valid", resp_valid, 0);
        sb_q.delete();
        exp_rd.delete();
        exp_wr_a.delete();
        exp_wr_d.delete();
        clear_model();
        mhits   = '0;
        mmisses = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        do_req(0, 32'h10, '0, 1);

        repeat (250) begin
            if ($urandom % 20 == 0) begin
                do_flush($urandom % 2 == 1);
            end else begin
                a = {22'd0, 2'($urandom % 4), 4'($urandom % 16), 4'($urandom % 16)};
                do_req(($urandom % 10) < 3, a, $urandom, 1);
            end
        end
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
